// File: rtl/irq_ctrl_8_pkg.sv
// Shared constants for the 8-source interrupt controller: register map, TCTRL bits, VECT encoding.
package irq_ctrl_8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned SRC_W  = 7;
  localparam int unsigned CNT_W  = 16;

  localparam logic [ADDR_W-1:0] OFF_PEND    = 3'd0;
  localparam logic [ADDR_W-1:0] OFF_ENABLE  = 3'd1;
  localparam logic [ADDR_W-1:0] OFF_ACTIVE  = 3'd2;
  localparam logic [ADDR_W-1:0] OFF_VECT    = 3'd3;
  localparam logic [ADDR_W-1:0] OFF_TRLD_LO = 3'd4;
  localparam logic [ADDR_W-1:0] OFF_TRLD_HI = 3'd5;
  localparam logic [ADDR_W-1:0] OFF_TCTRL   = 3'd6;
  localparam logic [ADDR_W-1:0] OFF_NMIST   = 3'd7;

  localparam int unsigned TCTRL_RUN_BIT  = 0;
  localparam int unsigned TCTRL_AUTO_BIT = 1;

  localparam logic [DATA_W-1:0] VECT_NONE = 8'h80;

  // Index of the highest set active bit (bit 7 wins), or VECT_NONE when nothing is active.
  function automatic logic [DATA_W-1:0] vect_of(input logic [DATA_W-1:0] active);
    logic [DATA_W-1:0] v;
    v = VECT_NONE;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (active[i]) v = {5'b0, 3'(i)};
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector with a registered history flop.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Synchronizer keeps sampling through reset so it is already refilled when reset releases.
  always_ff @(posedge clk) begin
    meta_q <= async_i;
    sync_q <= meta_q;
  end

  // Edge history follows the synchronized level, including during reset, so a held level is no edge.
  always_ff @(posedge clk) begin
    hist_q <= sync_q;
  end

  assign rise_c = sync_q & ~hist_q & ~reset;

endmodule

// File: rtl/irq_ctrl_8.sv
// 8-bit interrupt controller: 7 edge sources + timer into PEND, NMI latch, priority vector.
module irq_ctrl_8
  import irq_ctrl_8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic              we,
  input  logic [SRC_W-1:0]  src,
  input  logic              nmi_src,
  output logic              irq,
  output logic              nmi
);

  logic [SRC_W-1:0]  src_rise_c;
  logic              nmi_rise_c;

  logic [DATA_W-1:0] pend_q,    pend_d;
  logic [DATA_W-1:0] enable_q,  enable_d;
  logic [DATA_W-1:0] trld_lo_q, trld_lo_d;
  logic [DATA_W-1:0] trld_hi_q, trld_hi_d;
  logic              run_q,     run_d;
  logic              auto_q,    auto_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              nmist_q,   nmist_d;
  logic              irq_q;
  logic              nmi_q;

  logic              wr_c;
  logic              tctrl_wr_c;
  logic              expire_c;
  logic [CNT_W-1:0]  reload_c;
  logic [DATA_W-1:0] active_c;
  logic [DATA_W-1:0] set_c;
  logic [DATA_W-1:0] tctrl_rd_c;

  for (genvar i = 0; i < int'(SRC_W); i++) begin : g_src
    irq_edge_sync u_src_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (src[i]),
      .rise_c  (src_rise_c[i])
    );
  end

  irq_edge_sync u_nmi_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (nmi_src),
    .rise_c  (nmi_rise_c)
  );

  // Next-state for registers and timer; hardware set events win over write-1-clear.
  always_comb begin
    pend_d     = pend_q;
    enable_d   = enable_q;
    trld_lo_d  = trld_lo_q;
    trld_hi_d  = trld_hi_q;
    run_d      = run_q;
    auto_d     = auto_q;
    cnt_d      = cnt_q;
    nmist_d    = nmist_q;

    wr_c       = cs & we;
    tctrl_wr_c = wr_c && (addr == OFF_TCTRL);
    active_c   = pend_q & enable_q;
    reload_c   = {trld_hi_q, trld_lo_q};
    expire_c   = run_q && (cnt_q == CNT_W'(1));
    set_c      = {src_rise_c, expire_c};

    if (wr_c) begin
      case (addr)
        OFF_PEND:    pend_d    = pend_q & ~din;
        OFF_ENABLE:  enable_d  = din;
        OFF_TRLD_LO: trld_lo_d = din;
        OFF_TRLD_HI: trld_hi_d = din;
        OFF_TCTRL: begin
          run_d  = din[TCTRL_RUN_BIT];
          auto_d = din[TCTRL_AUTO_BIT];
        end
        OFF_NMIST: begin
          if (din[0]) nmist_d = 1'b0;
        end
        default: ;
      endcase
    end

    pend_d  = pend_d | set_c;
    nmist_d = nmist_d | nmi_rise_c;

    // One-shot mode stops itself on expiry unless software rewrites TCTRL this cycle.
    if (expire_c && !auto_q && !tctrl_wr_c) run_d = 1'b0;

    // Start loads the reload value; running counts down and reloads on expiry; stopped freezes.
    if (tctrl_wr_c && din[TCTRL_RUN_BIT] && !run_q) begin
      cnt_d = reload_c;
    end else if (run_q) begin
      cnt_d = expire_c ? reload_c : (cnt_q - CNT_W'(1));
    end
  end

  // Register read mux; bus reads zero when not selected.
  always_comb begin
    tctrl_rd_c                 = '0;
    tctrl_rd_c[TCTRL_RUN_BIT]  = run_q;
    tctrl_rd_c[TCTRL_AUTO_BIT] = auto_q;
    dout = '0;
    if (cs) begin
      case (addr)
        OFF_PEND:    dout = pend_q;
        OFF_ENABLE:  dout = enable_q;
        OFF_ACTIVE:  dout = active_c;
        OFF_VECT:    dout = vect_of(active_c);
        OFF_TRLD_LO: dout = trld_lo_q;
        OFF_TRLD_HI: dout = trld_hi_q;
        OFF_TCTRL:   dout = tctrl_rd_c;
        OFF_NMIST:   dout = {7'b0, nmist_q};
        default:     dout = '0;
      endcase
    end
  end

  // State registers with synchronous reset; irq/nmi lag their sources by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      enable_q  <= '0;
      trld_lo_q <= '0;
      trld_hi_q <= '0;
      run_q     <= 1'b0;
      auto_q    <= 1'b0;
      cnt_q     <= '0;
      nmist_q   <= 1'b0;
      irq_q     <= 1'b0;
      nmi_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      enable_q  <= enable_d;
      trld_lo_q <= trld_lo_d;
      trld_hi_q <= trld_hi_d;
      run_q     <= run_d;
      auto_q    <= auto_d;
      cnt_q     <= cnt_d;
      nmist_q   <= nmist_d;
      irq_q     <= |active_c;
      nmi_q     <= nmist_q;
    end
  end

  assign irq = irq_q;
  assign nmi = nmi_q;

endmodule

// File: tb/tb_irq_ctrl_8.sv
// Directed bench for irq_ctrl_8: latency, priority vector, W1C races, timer modes, reset behaviour.
module tb_irq_ctrl_8;
  import irq_ctrl_8_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       we;
  logic [6:0] src;
  logic       nmi_src;
  logic       irq;
  logic       nmi;

  int checks   = 0;
  int failures = 0;

  irq_ctrl_8 dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .we      (we),
    .src     (src),
    .nmi_src (nmi_src),
    .irq     (irq),
    .nmi     (nmi)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    tick(1);
    cs = 1'b0; we = 1'b0; addr = '0; din = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    cs = 1'b1; addr = a;
    #1;
    chk(tag, dout, exp);
    cs = 1'b0; addr = '0;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0; src = '0; nmi_src = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(1);

    // Reset state
    rd_chk("rst_pend",   OFF_PEND,   8'h00);
    rd_chk("rst_enable", OFF_ENABLE, 8'h00);
    rd_chk("rst_vect",   OFF_VECT,   VECT_NONE);
    rd_chk("rst_tctrl",  OFF_TCTRL,  8'h00);
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_nmi", 8'(nmi), 8'h00);

    // Single source: 3 clk to PEND, irq one clk later, W1C drops irq next clk
    wr(OFF_ENABLE, 8'h08);
    src = 7'b0000100;
    tick(2);
    rd_chk("lat2_pend", OFF_PEND, 8'h00);
    tick(1);
    rd_chk("lat3_pend", OFF_PEND, 8'h08);
    chk("lat3_irq", 8'(irq), 8'h00);
    tick(1);
    chk("lat4_irq", 8'(irq), 8'h01);
    rd_chk("s3_vect",   OFF_VECT,   8'h03);
    rd_chk("s3_active", OFF_ACTIVE, 8'h08);
    src = '0;
    wr(OFF_PEND, 8'h08);
    chk("clr_irq_lag", 8'(irq), 8'h01);
    tick(1);
    chk("clr_irq", 8'(irq), 8'h00);
    rd_chk("clr_pend", OFF_PEND, 8'h00);

    // Priority: bits 1 and 6 together
    wr(OFF_ENABLE, 8'hFF);
    src = 7'b0100001;
    tick(3);
    rd_chk("pri_pend", OFF_PEND, 8'h42);
    rd_chk("pri_vect6", OFF_VECT, 8'h06);
    wr(OFF_PEND, 8'h40);
    rd_chk("pri_vect1", OFF_VECT, 8'h01);
    wr(OFF_PEND, 8'h02);
    rd_chk("pri_vect_none", OFF_VECT, VECT_NONE);
    src = '0;
    tick(3);

    // Read-only offsets ignore writes; deselected bus reads zero
    wr(OFF_ACTIVE, 8'hFF);
    wr(OFF_VECT, 8'hFF);
    rd_chk("ro_active", OFF_ACTIVE, 8'h00);
    rd_chk("ro_pend",   OFF_PEND,   8'h00);
    cs = 1'b0; addr = OFF_ENABLE;
    #1;
    chk("cs0_dout", dout, 8'h00);
    addr = '0;
    rd_chk("cs1_enable", OFF_ENABLE, 8'hFF);

    // Timer auto-reload R=5: PEND[0] every 5 clk
    wr(OFF_TRLD_LO, 8'h05);
    wr(OFF_TRLD_HI, 8'h00);
    wr(OFF_TCTRL, 8'h03);
    tick(4);
    rd_chk("ar_t4_pend", OFF_PEND, 8'h00);
    tick(1);
    rd_chk("ar_t5_pend", OFF_PEND, 8'h01);
    wr(OFF_PEND, 8'h01);
    tick(3);
    rd_chk("ar_t9_pend", OFF_PEND, 8'h00);
    tick(1);
    rd_chk("ar_t10_pend", OFF_PEND, 8'h01);
    wr(OFF_TCTRL, 8'h00);
    wr(OFF_PEND, 8'h01);
    rd_chk("ar_stop_tctrl", OFF_TCTRL, 8'h00);

    // One-shot R=5
    wr(OFF_TCTRL, 8'h01);
    tick(4);
    rd_chk("os_t4_pend",  OFF_PEND,  8'h00);
    rd_chk("os_t4_tctrl", OFF_TCTRL, 8'h01);
    tick(1);
    rd_chk("os_t5_pend",  OFF_PEND,  8'h01);
    rd_chk("os_t5_tctrl", OFF_TCTRL, 8'h00);
    wr(OFF_PEND, 8'h01);
    tick(10);
    rd_chk("os_no_refire", OFF_PEND, 8'h00);

    // R=0 gives a 65536 clk period
    wr(OFF_TRLD_LO, 8'h00);
    wr(OFF_TCTRL, 8'h01);
    tick(65535);
    rd_chk("r0_t65535_pend",  OFF_PEND,  8'h00);
    rd_chk("r0_t65535_tctrl", OFF_TCTRL, 8'h01);
    tick(1);
    rd_chk("r0_t65536_pend",  OFF_PEND,  8'h01);
    rd_chk("r0_t65536_tctrl", OFF_TCTRL, 8'h00);
    wr(OFF_PEND, 8'h01);

    // Edge coincident with W1C of the same bit: set wins (PEND and NMIST)
    src = 7'b0001000;
    tick(2);
    wr(OFF_PEND, 8'h10);
    rd_chk("race_pend", OFF_PEND, 8'h10);
    wr(OFF_PEND, 8'h10);
    rd_chk("race_pend_clr", OFF_PEND, 8'h00);
    src = '0;
    nmi_src = 1'b1;
    tick(2);
    wr(OFF_NMIST, 8'h01);
    rd_chk("race_nmist", OFF_NMIST, 8'h01);
    chk("race_nmi_lag", 8'(nmi), 8'h00);
    tick(1);
    chk("race_nmi", 8'(nmi), 8'h01);
    wr(OFF_NMIST, 8'hFF);
    rd_chk("nmist_clr", OFF_NMIST, 8'h00);
    tick(1);
    chk("nmi_clr", 8'(nmi), 8'h00);
    nmi_src = 1'b0;
    tick(3);

    // Source held high across reset release produces no edge
    reset = 1'b1;
    src = 7'b0000010;
    tick(4);
    reset = 1'b0;
    tick(5);
    rd_chk("held_pend",   OFF_PEND,   8'h00);
    rd_chk("held_enable", OFF_ENABLE, 8'h00);

    // Reset mid-count aborts the timer
    wr(OFF_TRLD_LO, 8'h64);
    wr(OFF_TRLD_HI, 8'h00);
    wr(OFF_TCTRL, 8'h01);
    tick(50);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(120);
    rd_chk("abort_pend",  OFF_PEND,    8'h00);
    rd_chk("abort_tctrl", OFF_TCTRL,   8'h00);
    rd_chk("abort_trld",  OFF_TRLD_LO, 8'h00);
    src = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
